// File: rtl/tv80_bus_pkg.sv
// Shared types for the tv80 memory/I-O bridge: FSM states, request classes, wait counter width.
package tv80_bus_pkg;

   localparam int          WCTR_W       = 4;
   localparam logic [7:0]  IACK_DEFAULT = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ISSUE,
      ST_CAPTURE,
      ST_DONE
   } bridge_state_t;

   typedef enum logic [2:0] {
      RQ_NONE,
      RQ_IACK,
      RQ_MRD,
      RQ_MWR,
      RQ_IORD,
      RQ_IOWR
   } req_cls_t;

   // Priority order matters: an M1+IORQ cycle must never be seen as an I/O access.
   function automatic req_cls_t decode_req(input logic mreq_n, input logic iorq_n,
                                           input logic rd_n, input logic wr_n,
                                           input logic m1_n, input logic rfsh_n);
      req_cls_t cls;
      cls = RQ_NONE;
      if (!m1_n && !iorq_n)                cls = RQ_IACK;
      else if (!mreq_n && rfsh_n && !rd_n) cls = RQ_MRD;
      else if (!mreq_n && rfsh_n && !wr_n) cls = RQ_MWR;
      else if (!iorq_n && m1_n && !rd_n)   cls = RQ_IORD;
      else if (!iorq_n && m1_n && !wr_n)   cls = RQ_IOWR;
      return cls;
   endfunction

endpackage

// File: rtl/mem_bridge_wait_ctr.sv
// Loadable down-counter that times the programmable wait-state window; saturates at zero.
module mem_bridge_wait_ctr
   import tv80_bus_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load,
   input  logic [WCTR_W-1:0] i_load_val,
   input  logic              i_dec,
   output logic [WCTR_W-1:0] o_cnt,
   output logic              o_zero
);

   logic [WCTR_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_dec && (r_cnt != '0))
         r_cnt <= r_cnt - WCTR_W'(1);
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tv80_mem_bridge.sv
// tv80s bus bridge: one RAM port, one I/O port, registered read data, programmable wait states.
// Define MEM_BRIDGE_ROM_PROTECT_EN to suppress (and count) writes below ROM_SIZE.
module tv80_mem_bridge
   import tv80_bus_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [15:0] ROM_SIZE    = 16'h4000,
   parameter logic [7:0]  IACK_DATA   = IACK_DEFAULT
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_cpu_a,
   input  logic [7:0]  i_cpu_do,
   output logic [7:0]  o_cpu_di,
   input  logic        i_mreq_n,
   input  logic        i_iorq_n,
   input  logic        i_rd_n,
   input  logic        i_wr_n,
   input  logic        i_m1_n,
   input  logic        i_rfsh_n,
   output logic        o_wait_n,
   output logic [15:0] o_ram_addr,
   output logic [7:0]  o_ram_wdata,
   output logic        o_ram_we,
   output logic        o_ram_re,
   input  logic [7:0]  i_ram_rdata,
   output logic [7:0]  o_io_addr,
   output logic [7:0]  o_io_wdata,
   output logic        o_io_we,
   input  logic [7:0]  i_io_rdata,
   output logic [7:0]  o_wp_hits
);

   localparam logic [WCTR_W-1:0] WAIT_LD = WCTR_W'(WAIT_CYCLES);

   bridge_state_t r_state, w_next;
   req_cls_t      r_cls, w_req, w_cls;
   logic [7:0]    r_cpu_di, r_ram_wdata, r_io_addr, r_io_wdata;
   logic [15:0]   r_ram_addr, w_addr;
   logic          r_wait_n, r_ram_we, r_ram_re, r_io_we;
   logic          w_start, w_iack, w_load, w_dec, w_issue, w_capture, w_wp_block;
   logic [WCTR_W-1:0] w_cnt;
   logic          w_zero;

   assign w_req  = decode_req(i_mreq_n, i_iorq_n, i_rd_n, i_wr_n, i_m1_n, i_rfsh_n);
   // Without wait states the strobe is issued on the sampling edge, so use the live request there.
   assign w_cls  = (r_state == ST_IDLE) ? w_req : r_cls;
   assign w_addr = (r_state == ST_IDLE) ? i_cpu_a : r_ram_addr;

   mem_bridge_wait_ctr u_wait_ctr (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_load),
      .i_load_val (WAIT_LD),
      .i_dec      (w_dec),
      .o_cnt      (w_cnt),
      .o_zero     (w_zero)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_start   = 1'b0;
      w_iack    = 1'b0;
      w_load    = 1'b0;
      w_dec     = 1'b0;
      w_issue   = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req == RQ_IACK) begin
               w_iack = 1'b1;
               w_next = ST_DONE;
            end else if (w_req != RQ_NONE) begin
               w_start = 1'b1;
               w_load  = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  w_issue = 1'b1;
                  w_next  = ST_ISSUE;
               end else begin
                  w_next  = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            w_dec = 1'b1;
            if ((w_cnt == WCTR_W'(1)) || w_zero) begin
               w_issue = 1'b1;
               w_next  = ST_ISSUE;
            end
         end
         ST_ISSUE:   w_next = ST_CAPTURE;
         ST_CAPTURE: begin
            w_capture = 1'b1;
            w_next    = ST_DONE;
         end
         ST_DONE: begin
            if (i_mreq_n && i_iorq_n) w_next = ST_IDLE;
         end
         default:    w_next = ST_IDLE;
      endcase
   end

`ifdef MEM_BRIDGE_ROM_PROTECT_EN
   logic [7:0] r_wp_hits;

   assign w_wp_block = (w_cls == RQ_MWR) && (w_addr < ROM_SIZE);

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_wp_hits <= 8'h00;
      else if (w_issue && w_wp_block)
         r_wp_hits <= r_wp_hits + 8'd1;
   end

   assign o_wp_hits = r_wp_hits;
`else
   logic w_unused_rom;

   assign w_unused_rom = ^{ROM_SIZE, w_addr};
   assign w_wp_block   = 1'b0;
   assign o_wp_hits    = 8'h00;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cls       <= RQ_NONE;
         r_cpu_di    <= 8'hFF;
         r_wait_n    <= 1'b1;
         r_ram_addr  <= 16'h0000;
         r_ram_wdata <= 8'h00;
         r_io_addr   <= 8'h00;
         r_io_wdata  <= 8'h00;
         r_ram_re    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_io_we     <= 1'b0;
      end else begin
         r_ram_re <= w_issue && (w_cls == RQ_MRD);
         r_ram_we <= w_issue && (w_cls == RQ_MWR) && !w_wp_block;
         r_io_we  <= w_issue && (w_cls == RQ_IOWR);
         if (w_start) begin
            r_cls       <= w_req;
            r_wait_n    <= 1'b0;
            r_ram_addr  <= i_cpu_a;
            r_ram_wdata <= i_cpu_do;
            r_io_addr   <= i_cpu_a[7:0];
            r_io_wdata  <= i_cpu_do;
         end
         if (w_iack)
            r_cpu_di <= IACK_DATA;
         if (w_capture) begin
            r_wait_n <= 1'b1;
            if (r_cls == RQ_MRD)       r_cpu_di <= i_ram_rdata;
            else if (r_cls == RQ_IORD) r_cpu_di <= i_io_rdata;
         end
      end
   end

   assign o_cpu_di    = r_cpu_di;
   assign o_wait_n    = r_wait_n;
   assign o_ram_addr  = r_ram_addr;
   assign o_ram_wdata = r_ram_wdata;
   assign o_ram_we    = r_ram_we;
   assign o_ram_re    = r_ram_re;
   assign o_io_addr   = r_io_addr;
   assign o_io_wdata  = r_io_wdata;
   assign o_io_we     = r_io_we;

endmodule
